// File: rtl/mem_port_arbiter.sv
// Two-port RAM sequencer: port 0 read-only fetch, port 1 load/store, plus a
// one-address-per-cycle zero-fill sweep that owns the RAM while it runs.
module mem_port_arbiter #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] CLR_LAST = 16'hFFFF,
    parameter bit                FAIR     = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_gnt,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              rr_pref;

    // Everything combinational is held quiet while reset is asserted so the
    // RAM never sees a stray write or grant during the reset cycle.
    always_comb begin
        state_nxt = state;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        clr_busy  = 1'b0;
        if (!reset) begin
            case (state)
                ARB: begin
                    if (clr_start) begin
                        state_nxt = CLEAR;
                    end else if (p0_req && (!p1_req || !FAIR || !rr_pref)) begin
                        p0_gnt = 1'b1;
                    end else if (p1_req) begin
                        p1_gnt = 1'b1;
                    end
                    if (p0_gnt) begin
                        mem_addr = p0_addr;
                    end
                    if (p1_gnt) begin
                        mem_addr  = p1_addr;
                        mem_wdata = p1_wdata;
                        mem_we    = p1_we;
                    end
                end
                CLEAR: begin
                    mem_addr = cnt;
                    mem_we   = 1'b1;
                    clr_busy = 1'b1;
                    if (cnt == CLR_LAST) begin
                        state_nxt = ARB;
                    end
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    // Compare-before-increment ends the sweep at CLR_LAST, so an all-ones
    // CLR_LAST never wraps into a second pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB;
            cnt       <= '0;
            rr_pref   <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            p0_rvalid <= p0_gnt;
            p1_rvalid <= p1_gnt && !p1_we;
            clr_done  <= (state == CLEAR) && (cnt == CLR_LAST);
            if (p0_gnt) begin
                p0_rdata <= mem_rdata;
            end
            if (p1_gnt && !p1_we) begin
                p1_rdata <= mem_rdata;
            end
            if (p0_gnt) begin
                rr_pref <= 1'b1;
            end else if (p1_gnt) begin
                rr_pref <= 1'b0;
            end
            if (state == CLEAR && cnt != CLR_LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Runs a fixed-priority and a round-robin arbiter side by side on shared
// stimulus, each with its own RAM, against a cycle-level behavioural model.
module tb_mem_port_arbiter;

    localparam logic [15:0] LAST = 16'h000B;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p1_req, p1_we, clr_start;
    logic [15:0] p0_addr, p1_addr;
    logic [7:0]  p1_wdata;

    logic        p0_gnt [2], p1_gnt [2], p0_rvalid [2], p1_rvalid [2];
    logic        clr_busy [2], clr_done [2], mem_we [2];
    logic [7:0]  p0_rdata [2], p1_rdata [2], mem_wdata [2], mem_rdata [2];
    logic [15:0] mem_addr [2];

    logic [7:0]  ram  [2][65536];
    logic [7:0]  mref [2][65536];

    bit          m_clr [2], m_pref [2], e_rv0 [2], e_rv1 [2], e_done [2];
    logic [15:0] m_cnt [2];
    logic [7:0]  e_rd0 [2], e_rd1 [2];

    int nchk = 0;
    int nfail = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(8), .CLR_LAST(LAST), .FAIR(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt[0]),
        .p0_rdata(p0_rdata[0]), .p0_rvalid(p0_rvalid[0]),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt[0]), .p1_rdata(p1_rdata[0]), .p1_rvalid(p1_rvalid[0]),
        .clr_start(clr_start), .clr_busy(clr_busy[0]), .clr_done(clr_done[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
        .mem_rdata(mem_rdata[0])
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(8), .CLR_LAST(LAST), .FAIR(1'b1)) dut1 (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt[1]),
        .p0_rdata(p0_rdata[1]), .p0_rvalid(p0_rvalid[1]),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt[1]), .p1_rdata(p1_rdata[1]), .p1_rvalid(p1_rvalid[1]),
        .clr_start(clr_start), .clr_busy(clr_busy[1]), .clr_done(clr_done[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
        .mem_rdata(mem_rdata[1])
    );

    assign mem_rdata[0] = ram[0][mem_addr[0]];
    assign mem_rdata[1] = ram[1][mem_addr[1]];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_we[i]) ram[i][mem_addr[i]] <= mem_wdata[i];
        end
    end

    task automatic checkOutput(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("[TB] FAIL %s (fair=%0d) actual=%0h required=%0h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r0, input logic [15:0] a0, input bit r1, input bit we,
                                 input logic [15:0] a1, input logic [7:0] wd, input bit cs);
        @(posedge clk);
        #1;
        p0_req = r0; p0_addr = a0; p1_req = r1; p1_we = we;
        p1_addr = a1; p1_wdata = wd; clr_start = cs;
    endtask

    // Reference: decide this cycle's outputs from the rules, compare, then
    // advance the model to what the coming clock edge must produce.
    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 2; i++) begin : model
                bit          g0, g1, xwe, xbusy;
                logic [15:0] xaddr;
                g0 = 1'b0; g1 = 1'b0;
                if (!reset && !m_clr[i] && !clr_start) begin
                    if (p0_req && p1_req) begin
                        if (i == 1 && m_pref[i]) g1 = 1'b1;
                        else g0 = 1'b1;
                    end else begin
                        g0 = p0_req;
                        g1 = p1_req;
                    end
                end
                xbusy = !reset && m_clr[i];
                xwe   = xbusy || (g1 && p1_we);
                xaddr = xbusy ? m_cnt[i] : g0 ? p0_addr : g1 ? p1_addr : 16'h0;

                checkOutput("p0_gnt", i, p0_gnt[i], g0);
                checkOutput("p1_gnt", i, p1_gnt[i], g1);
                checkOutput("mem_we", i, mem_we[i], xwe);
                checkOutput("mem_addr", i, mem_addr[i], xaddr);
                checkOutput("clr_busy", i, clr_busy[i], xbusy);
                if (xwe) checkOutput("mem_wdata", i, mem_wdata[i], xbusy ? 8'h00 : p1_wdata);
                checkOutput("p0_rvalid", i, p0_rvalid[i], e_rv0[i]);
                checkOutput("p1_rvalid", i, p1_rvalid[i], e_rv1[i]);
                checkOutput("p0_rdata", i, p0_rdata[i], e_rd0[i]);
                checkOutput("p1_rdata", i, p1_rdata[i], e_rd1[i]);
                checkOutput("clr_done", i, clr_done[i], e_done[i]);

                if (reset) begin
                    m_clr[i] = 0; m_cnt[i] = 0; m_pref[i] = 0;
                    e_rv0[i] = 0; e_rv1[i] = 0; e_done[i] = 0;
                    e_rd0[i] = 0; e_rd1[i] = 0;
                end else begin
                    e_rv0[i] = g0;
                    if (g0) e_rd0[i] = mref[i][p0_addr];
                    e_rv1[i] = g1 && !p1_we;
                    if (g1 && !p1_we) e_rd1[i] = mref[i][p1_addr];
                    if (g1 && p1_we) mref[i][p1_addr] = p1_wdata;
                    if (g0) m_pref[i] = 1;
                    else if (g1) m_pref[i] = 0;
                    e_done[i] = m_clr[i] && (m_cnt[i] == LAST);
                    if (m_clr[i]) begin
                        mref[i][m_cnt[i]] = 8'h00;
                        if (m_cnt[i] == LAST) begin
                            m_clr[i] = 0;
                            m_cnt[i] = 0;
                        end else begin
                            m_cnt[i] = m_cnt[i] + 16'd1;
                        end
                    end else if (clr_start) begin
                        m_clr[i] = 1;
                    end
                end
            end
        end
    end

    initial begin
        int  nwr;
        int  ndone;
        bit  seen;

        for (int a = 0; a < 65536; a++) begin
            for (int i = 0; i < 2; i++) begin
                ram[i][a]  = 8'h80 | 8'(a[6:0]);
                mref[i][a] = 8'h80 | 8'(a[6:0]);
            end
        end
        reset = 1'b1; p0_req = 0; p1_req = 0; p1_we = 0; clr_start = 0;
        p0_addr = 0; p1_addr = 0; p1_wdata = 0;
        @(posedge clk);
        run = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_p0_rdata", i, p0_rdata[i], 8'h00);
            checkOutput("reset_p1_rvalid", i, p1_rvalid[i], 1'b0);
            checkOutput("reset_clr_busy", i, clr_busy[i], 1'b0);
        end

        // Both ports requesting: fixed priority vs alternation
        applyStimulus(1, 16'h0002, 1, 0, 16'h0003, 8'h00, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("fixed_p0_wins", 0, p0_gnt[0], 1'b1);
            checkOutput("rr_p0_gnt", 1, p0_gnt[1], (k % 2) == 0);
            checkOutput("rr_p1_gnt", 1, p1_gnt[1], (k % 2) == 1);
            if (k < 3) begin
                @(posedge clk);
                #1;
            end
        end

        applyStimulus(1, 16'h0002, 0, 0, 16'h0000, 8'h00, 0);
        @(negedge clk);
        checkOutput("rd_gnt", 0, p0_gnt[0], 1'b1);
        checkOutput("rd_addr", 0, mem_addr[0], 16'h0002);
        applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0);
        @(negedge clk);
        checkOutput("rd_rvalid", 0, p0_rvalid[0], 1'b1);
        checkOutput("rd_data", 0, p0_rdata[0], 8'h82);
        checkOutput("model_rd0", 0, e_rd0[0], 8'h82);

        applyStimulus(0, 16'h0000, 1, 1, 16'h0010, 8'h5A, 0);
        @(negedge clk);
        checkOutput("wr_we", 0, mem_we[0], 1'b1);
        checkOutput("wr_wdata", 0, mem_wdata[0], 8'h5A);
        applyStimulus(0, 16'h0000, 1, 0, 16'h0010, 8'h00, 0);
        @(negedge clk);
        checkOutput("wr_no_rvalid", 0, p1_rvalid[0], 1'b0);
        applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0);
        @(negedge clk);
        checkOutput("rb_rvalid", 0, p1_rvalid[0], 1'b1);
        checkOutput("rb_data", 0, p1_rdata[0], 8'h5A);

        // Sweep started alongside a port 1 request; port 0 joins mid-sweep
        applyStimulus(0, 16'h0000, 1, 0, 16'h0005, 8'h00, 1);
        @(negedge clk);
        checkOutput("clr_blocks_p1", 0, p1_gnt[0], 1'b0);
        checkOutput("clr_blocks_p1", 1, p1_gnt[1], 1'b0);
        applyStimulus(0, 16'h0000, 1, 0, 16'h0005, 8'h00, 0);
        nwr = 0;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (clr_done[0]) seen = 1;
            else if (mem_we[0]) nwr++;
            if (!seen) begin
                @(posedge clk);
                #1;
                if (c == 4) begin
                    p0_req = 1; p0_addr = 16'h0001;
                end
            end
        end
        checkOutput("sweep_done_seen", 0, seen, 1'b1);
        checkOutput("sweep_writes", 0, nwr, 12);
        checkOutput("done_cycle_p0_gnt", 0, p0_gnt[0], 1'b1);
        applyStimulus(0, 16'h0000, 1, 0, 16'h0005, 8'h00, 0);
        @(negedge clk);
        checkOutput("p1_after_sweep", 0, p1_gnt[0], 1'b1);
        applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0);
        for (int a = 0; a <= 11; a++) checkOutput("ram_cleared", 0, ram[0][a], 8'h00);
        checkOutput("ram_untouched", 0, ram[0][12], 8'h8C);

        // Reset lands on the fifth sweep cycle
        applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00, 1);
        applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_sweep_busy", 0, clr_busy[0], 1'b0);
        ndone = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (clr_done[0] || clr_done[1]) ndone++;
        end
        checkOutput("rst_sweep_no_done", 0, ndone, 0);
        applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00, 1);
        applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0);
        @(negedge clk);
        checkOutput("restart_addr0", 0, mem_addr[0], 16'h0000);
        checkOutput("restart_busy", 0, clr_busy[0], 1'b1);
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
        end

        // Random traffic with occasional sweeps and resets
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            reset     = ($urandom_range(0, 299) == 0);
            clr_start = ($urandom_range(0, 99) == 0);
            p0_req    = 1'($urandom_range(0, 1));
            p0_addr   = 16'($urandom_range(0, 31));
            p1_req    = 1'($urandom_range(0, 1));
            p1_we     = 1'($urandom_range(0, 1));
            p1_addr   = 16'($urandom_range(0, 31));
            p1_wdata  = 8'($urandom);
        end
        applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the 8-bit-data, 16-bit-address program/data RAM between two requesters.
  - Port 0 is instruction fetch and is read-only.
  - Port 1 is data load/store and can read or write.
- Provides a sequenced memory-clear engine. It writes zero to every address, one address per cycle, and replaces any combinational bulk clear.
- Sits between the CPU control unit and the RAM. The RAM read is combinational; its write is clocked.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- CLR_LAST, 16'hFFFF, last address written by the clear sweep. The sweep covers 0..CLR_LAST.
- FAIR, 0, arbitration mode. 0 = fixed priority to port 0; 1 = round-robin.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 read request; held until granted.
- p0_addr  in  ADDR_W  port 0 address.
- p0_gnt  out  1  port 0 grant, combinational, same cycle as access.
- p0_rdata  out  DATA_W  port 0 registered read data.
- p0_rvalid  out  1  port 0 read data valid, one-cycle pulse.
- p1_req  in  1  port 1 request; held until granted.
- p1_we  in  1  port 1 write enable (1 = write, 0 = read).
- p1_addr  in  ADDR_W  port 1 address.
- p1_wdata  in  DATA_W  port 1 write data.
- p1_gnt  out  1  port 1 grant.
- p1_rdata  out  DATA_W  port 1 registered read data.
- p1_rvalid  out  1  port 1 read valid pulse; never pulses for writes.
- clr_start  in  1  single-cycle pulse that starts the clear sweep.
- clr_busy  out  1  high while the sweep is running.
- clr_done  out  1  one-cycle pulse on sweep completion.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM combinational read data.

Behaviour:
- State machine has two states, ARB and CLEAR. Reset state is ARB.
- Reset values:
  - All gnt, rvalid, mem_we, clr_busy and clr_done are 0.
  - p0_rdata, p1_rdata, mem_addr and mem_wdata are 0.
  - Sweep counter is 0. Round-robin pointer points to port 0.
- ARB state:
  - At most one grant per cycle.
  - The granted port's address (and write data/we for port 1) drive the mem_* outputs combinationally in the same cycle.
  - With no grant: mem_we = 0, mem_addr = 0.
- Read latency:
  - mem_rdata is captured into px_rdata at the grant edge.
  - px_rvalid is 1 on the following cycle only.
  - px_rdata holds its value until the next read completes on that port.
- Port 1 write: mem_we = 1 for exactly the grant cycle. No rvalid is produced.
- Arbitration when both ports request:
  - FAIR = 0: port 0 always wins.
  - FAIR = 1: the winner is the port not granted most recently. The pointer updates only on a grant.
- A requester sees gnt, then drops or changes req on the next cycle. req held high means back-to-back accesses are allowed, one per cycle.
- clr_start handling in ARB:
  - On clr_start, go to CLEAR next cycle. No grant is issued in the clr_start cycle, even with req present.
  - clr_start takes priority over requests.
- CLEAR state, each cycle:
  - mem_addr = counter, mem_wdata = 0, mem_we = 1, clr_busy = 1.
  - Counter increments each cycle.
  - All gnt = 0; requests wait without being dropped.
- CLEAR exit: after writing CLR_LAST, next state is ARB. clr_done pulses on that first ARB cycle, and the counter resets to 0.
- Counter wrap: CLR_LAST = FFFF ends the sweep without the counter wrapping into a second pass.
- clr_start during CLEAR is ignored. A sweep takes exactly CLR_LAST+1 write cycles.
- Reset mid-sweep: returns to ARB next cycle with the counter at 0. No clr_done pulse, and no partial-completion indication.
- Reset also cancels a pending rvalid: rvalid does not pulse in the cycle after reset.

Test Plan:
- Port 0 reads address 0x0002 while RAM[2] = 0x82 -> p0_gnt = 1 same cycle, mem_addr = 0x0002; next cycle p0_rvalid = 1 and p0_rdata = 0x82.
- Port 1 writes 0x5A to 0x0010, then reads 0x0010 -> write cycle has mem_we = 1, mem_wdata = 0x5A, and no p1_rvalid; the read returns 0x5A with p1_rvalid one cycle after its grant.
- Both ports request continuously for 4 cycles:
  - FAIR = 0 -> grants are p0, p0, p0, p0.
  - FAIR = 1 -> grants are p0, p1, p0, p1.
- CLR_LAST = 0x000B, RAM preloaded with nonzero values, clr_start pulsed -> 12 cycles of mem_we = 1 at addresses 0..0xB with data 0; clr_done pulses once; all 12 locations read back 0x00. A p0_req asserted mid-sweep is granted on the cycle of clr_done.
- clr_start and p1_req in the same cycle -> no p1_gnt that cycle, sweep runs, and p1 is granted after the sweep ends.
- reset asserted on the 5th sweep cycle -> clr_busy = 0 next cycle, clr_done never pulses; a new clr_start restarts the sweep from address 0.
